// File: rtl/cache_fill_arbiter.sv
// Round-robin multi-port cache-miss fill controller: streams one block per grant from pipelined memory.
// Optional critical-word-first ordering with early stall release: define CRITICAL_WORD_FIRST_EN.
module cache_fill_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int OFF_W          = $clog2(WORDS_PER_BLOCK) + 1,
  localparam int GRANT_W        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        miss_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] miss_addr,
  input  logic                        mem_data_valid,
  output logic [NUM_PORTS-1:0]        stall,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [NUM_PORTS-1:0]        fill_wen,
  output logic [OFF_W-1:0]            fill_offset,
  output logic [NUM_PORTS-1:0]        tag_wen,
  output logic                        busy,
  output logic [GRANT_W-1:0]          grant_id
);

  localparam int IDX_W  = OFF_W - 1;
  localparam int BASE_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [GRANT_W-1:0] LAST_PORT = GRANT_W'(NUM_PORTS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t               state;
  logic [GRANT_W-1:0]   rr_ptr;
  logic [BASE_W-1:0]    base;
  logic [IDX_W-1:0]     start;
  logic [IDX_W-1:0]     issue_cnt;
  logic [IDX_W-1:0]     recv_cnt;
  logic [IDX_W-1:0]     next_issue;
  logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
  logic [NUM_PORTS*OFF_W-1:0] unused_addr_lsbs;
  logic                 pick_found;
  logic [GRANT_W-1:0]   pick_id;
  logic [GRANT_W-1:0]   scan_idx;
  logic [IDX_W-1:0]     pick_start;
  logic [NUM_PORTS-1:0] grant_onehot;
  logic                 ret_accept;
  logic                 ret_last;
  logic                 issue_last;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port_addr
    assign port_addr[p] = miss_addr[p*ADDR_W +: ADDR_W];
    assign unused_addr_lsbs[p*OFF_W +: OFF_W] = port_addr[p][OFF_W-1:0];
  end

  // Scan downward so the lowest distance from rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    scan_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      scan_idx = GRANT_W'((int'(rr_ptr) + i) % NUM_PORTS);
      if (miss_valid[scan_idx]) begin
        pick_found = 1'b1;
        pick_id    = scan_idx;
      end
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  assign pick_start = port_addr[pick_id][OFF_W-1:1];
`else
  assign pick_start = '0;
`endif

  assign next_issue   = issue_cnt + 1'b1;
  assign grant_onehot = NUM_PORTS'(1) << grant_id;
  assign ret_accept   = (state != IDLE) && mem_data_valid;
  assign ret_last     = ret_accept && (recv_cnt == LAST_IDX);
  assign issue_last   = (state == ISSUE) && (issue_cnt == LAST_IDX);
  assign fill_wen     = ret_accept ? grant_onehot : '0;
  assign tag_wen      = ret_last ? grant_onehot : '0;
  assign fill_offset  = ret_accept ? {start + recv_cnt, 1'b0} : '0;
  assign busy         = (state != IDLE);

`ifdef CRITICAL_WORD_FIRST_EN
  // Requester may resume once its critical word has landed; the rest of the block fills behind it.
  logic crit_done;
  assign stall = miss_valid & ~(crit_done ? grant_onehot : '0);
`else
  assign stall = miss_valid;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      base      <= '0;
      start     <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '1;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_done <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= ISSUE;
            grant_id  <= pick_id;
            base      <= port_addr[pick_id][ADDR_W-1:OFF_W];
            start     <= pick_start;
            rr_ptr    <= (pick_id == LAST_PORT) ? '0 : pick_id + 1'b1;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_addr  <= {port_addr[pick_id][ADDR_W-1:OFF_W], pick_start, 1'b0};
          end
        end
        ISSUE, DRAIN: begin
          if (state == ISSUE) begin
            if (issue_last) begin
              state     <= DRAIN;
              issue_cnt <= '0;
              mem_req   <= 1'b0;
              mem_addr  <= '1;
            end else begin
              issue_cnt <= next_issue;
              mem_addr  <= {base, start + next_issue, 1'b0};
            end
          end
          if (ret_accept) begin
            recv_cnt <= recv_cnt + 1'b1;
          end
`ifdef CRITICAL_WORD_FIRST_EN
          if (ret_accept && (recv_cnt == '0)) begin
            crit_done <= 1'b1;
          end
`endif
          // Completion is counted only on returned words, so it overrides any issue-side update.
          if (ret_last) begin
            state     <= IDLE;
            recv_cnt  <= '0;
            issue_cnt <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '1;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_done <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter (default parameters: 2 ports, 16-bit addresses, 8-word blocks).
// Works with or without CRITICAL_WORD_FIRST_EN; expected word order follows the build.
module tb_cache_fill_arbiter;

  localparam int NP = 2;
  localparam int AW = 16;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF_ON = 1'b1;
`else
  localparam bit CWF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] miss_valid;
  logic [NP*AW-1:0] miss_addr;
  logic          mem_data_valid;
  logic [NP-1:0] stall;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [NP-1:0] fill_wen;
  logic [3:0]    fill_offset;
  logic [NP-1:0] tag_wen;
  logic          busy;
  logic [0:0]    grant_id;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  cache_fill_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .miss_valid     (miss_valid),
    .miss_addr      (miss_addr),
    .mem_data_valid (mem_data_valid),
    .stall          (stall),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .fill_wen       (fill_wen),
    .fill_offset    (fill_offset),
    .tag_wen        (tag_wen),
    .busy           (busy),
    .grant_id       (grant_id)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE cycle; presents the miss, plays memory returning lat cycles after each
  // request, and leaves in the first IDLE cycle after the tag write with the port's miss cleared.
  task automatic apply_stimulus(input int port, input logic [15:0] addr, input int lat,
                                input int drop_k, input logic [1:0] others);
    logic [1:0] onehot;
    logic [2:0] start;
    logic [2:0] word;
    logic       crit;
    onehot = 2'(1 << port);
    start  = CWF_ON ? addr[3:1] : 3'd0;
    miss_addr[port*AW +: AW] = addr;
    miss_valid     = others | onehot;
    mem_data_valid = 1'b0;
    #1;
    check_output("entry_busy", busy, 0);
    for (int k = 1; k <= lat + 9; k++) begin
      tick();
      mem_data_valid = (k > lat) && (k <= lat + 8);
      miss_valid = others | (((k < drop_k) && (k <= lat + 8)) ? onehot : 2'b00);
      #1;
      crit = CWF_ON && (k >= lat + 2) && (k <= lat + 8);
      if (k == 1) check_output("grant_id", grant_id, port);
      check_output("stall", stall, miss_valid & ~(crit ? onehot : 2'b00));
      check_output("mem_req", mem_req, (k <= 8));
      if (k <= 8) begin
        word = start + 3'(k - 1);
        check_output("mem_addr", mem_addr, {addr[15:4], word, 1'b0});
      end
      check_output("fill_wen", fill_wen, ((k > lat) && (k <= lat + 8)) ? onehot : 2'b00);
      if ((k > lat) && (k <= lat + 8)) begin
        word = start + 3'(k - lat - 1);
        check_output("fill_offset", fill_offset, {word, 1'b0});
      end
      check_output("tag_wen", tag_wen, (k == lat + 8) ? onehot : 2'b00);
      check_output("busy", busy, (k <= lat + 8));
    end
  endtask

  initial begin
    rst            = 1'b0;
    miss_valid     = '0;
    miss_addr      = '0;
    mem_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_output("rst_busy", busy, 0);
    check_output("rst_mem_req", mem_req, 0);
    check_output("rst_mem_addr", mem_addr, 16'hFFFF);
    check_output("rst_fill_wen", fill_wen, 0);
    check_output("rst_tag_wen", tag_wen, 0);
    check_output("rst_grant_id", grant_id, 0);
    check_output("rst_fill_offset", fill_offset, 0);
    rst = 1'b1;

    $display("[TB] memory returns while idle");
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_data_valid = 1'b1;
      #1;
      check_output("idle_fill_wen", fill_wen, 0);
      check_output("idle_tag_wen", tag_wen, 0);
      check_output("idle_busy", busy, 0);
    end
    mem_data_valid = 1'b0;
    tick();

    $display("[TB] single D-cache miss");
    apply_stimulus(1, 16'h1236, 4, 99, 2'b00);

    $display("[TB] simultaneous misses, round-robin");
    miss_addr[AW +: AW] = 16'h0210;
    apply_stimulus(0, 16'h0100, 3, 99, 2'b10);
    apply_stimulus(1, 16'h0210, 3, 99, 2'b00);
    apply_stimulus(0, 16'h0520, 2, 99, 2'b10);
    apply_stimulus(1, 16'h0630, 2, 99, 2'b00);

    $display("[TB] miss dropped mid-issue");
    apply_stimulus(1, 16'h3456, 3, 4, 2'b00);

    $display("[TB] reset during fill");
    miss_addr[AW +: AW] = 16'h2000;
    miss_valid = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      tick();
      mem_data_valid = (k >= 3);
    end
    tick();
    rst            = 1'b0;
    mem_data_valid = 1'b1;
    miss_valid     = 2'b00;
    #1;
    check_output("abort_busy", busy, 0);
    check_output("abort_mem_req", mem_req, 0);
    check_output("abort_mem_addr", mem_addr, 16'hFFFF);
    check_output("abort_fill_wen", fill_wen, 0);
    check_output("abort_tag_wen", tag_wen, 0);
    check_output("abort_fill_offset", fill_offset, 0);
    check_output("abort_grant_id", grant_id, 0);
    check_output("abort_stall", stall, 0);
    tick();
    check_output("abort_tag_wen_hold", tag_wen, 0);
    rst            = 1'b1;
    mem_data_valid = 1'b0;
    apply_stimulus(1, 16'h2000, 2, 99, 2'b00);

    $display("[TB] mid-block miss address");
    apply_stimulus(0, 16'h4A0A, 4, 99, 2'b00);

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Parametrised multi-port cache-miss fill controller; next generation of the two-port (I/D) fill FSM.
- Arbitrates among NUM_PORTS miss requesters round-robin and streams a WORDS_PER_BLOCK-word block from pipelined memory, one address per cycle.
- Steers returned words into the granted port's data array and writes that port's tag on the final word.
- Sits between the I/D (and any extra) caches and the multi-cycle memory model.

Parameters:
NUM_PORTS, 2, number of miss requesters (port 0 = I-cache, port 1 = D-cache by convention)
ADDR_W, 16, byte address width
WORDS_PER_BLOCK, 8, 2-byte words per block; power of two, >= 2
OFF_W, log2(WORDS_PER_BLOCK)+1, byte-offset bits within a block (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
miss_valid  in  NUM_PORTS  per-port miss detected, level, held until fill completes
miss_addr  in  NUM_PORTS*ADDR_W  per-port miss byte address, port i at [i*ADDR_W +: ADDR_W]
mem_data_valid  in  1  memory returns one word this cycle, in issue order
stall  out  NUM_PORTS  per-port pipeline stall
mem_req  out  1  mem_addr valid this cycle
mem_addr  out  ADDR_W  word-aligned fetch address
fill_wen  out  NUM_PORTS  data-array write enable, one-hot to granted port
fill_offset  out  OFF_W  byte offset within the block of the word being written
tag_wen  out  NUM_PORTS  tag-array write enable, one-hot, final word only
busy  out  1  fill in progress
grant_id  out  log2(NUM_PORTS) (min 1)  currently granted port

Behaviour:
- Reset (rst=0, async): state IDLE; counters 0; round-robin pointer 0; all outputs 0; mem_addr all-ones.
- stall[i] = miss_valid[i], combinational, in every state.
- Arbitration, IDLE only: the first port with miss_valid, searching upward from rr_ptr with wrap, is latched as grant_id together with its miss_addr[ADDR_W-1:OFF_W] (base) in the same cycle. Next state is ISSUE.
- After a grant, rr_ptr becomes (grant+1) mod NUM_PORTS.
- ISSUE: mem_req=1 for exactly WORDS_PER_BLOCK consecutive cycles; mem_addr = {base, issue_cnt, 1'b0}. issue_cnt counts 0..WORDS_PER_BLOCK-1 and increments every cycle with no backpressure. Enter DRAIN after the last issue.
- Return path, active in ISSUE and DRAIN: each mem_data_valid pulse sets fill_wen[grant]=1 and fill_offset={recv_cnt,1'b0}, then increments recv_cnt.
- Final return (recv_cnt == WORDS_PER_BLOCK-1 with mem_data_valid): tag_wen[grant]=1 in the same cycle as the last fill_wen. State returns to IDLE; counters clear.
- Back-to-back fills: a new grant is possible the cycle after IDLE is re-entered, so the minimum gap between fills is 1 cycle.
- mem_data_valid in IDLE: ignored, no writes.
- Grant is locked for the whole fill. If miss_valid[grant] drops mid-fill, the fill still completes, including the tag write. Other ports' new misses wait.
- Memory latency is not a parameter; completion is counted purely on mem_data_valid. Data may arrive while ISSUE is still active.
- Reset asserted mid-fill aborts immediately. No partial tag write is ever produced.
- busy = (state != IDLE).

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined:
  - Latch start = miss_addr[OFF_W-1:1] at grant.
  - Issue word offsets start, start+1, ... modulo WORDS_PER_BLOCK, wrapping within the block.
  - fill_offset likewise equals {(start+recv_cnt) mod WORDS_PER_BLOCK, 1'b0}.
  - stall[grant] deasserts one cycle after the first (critical) word is written, even if miss_valid is still high. It stays low until tag_wen; all other stall behaviour is unchanged.
- Undefined: fetch always starts at offset 0; stall is purely miss_valid.

Test Plan:
- Single D miss, miss_addr[1]=16'h1236, memory returns 4 cycles after each request. Required: mem_addr 16'h1230,1232,...,123E over 8 consecutive cycles; 8 fill_wen[1] pulses at offsets 0,2,...,E; tag_wen[1] with the last pulse; busy low afterwards.
- miss_valid=2'b11 from IDLE after reset. Required: port 0 granted first, port 1 granted immediately after port 0's tag_wen. A second simultaneous pair then grants port 0 first again, because rr_ptr has wrapped back to 0.
- rst driven low in the cycle after the 3rd return. Required: all outputs 0 asynchronously and no tag_wen; after release, a re-presented miss refetches the full block from offset 0.
- miss_valid[1] dropped mid-ISSUE. Required: all 8 words still written and tag_wen[1] pulses.
- mem_data_valid pulses while IDLE with no miss. Required: no fill_wen, no tag_wen, state stays IDLE.
- CRITICAL_WORD_FIRST_EN defined, miss_addr=16'h4A0A. Required: mem_addr order 4A0A,4A0C,4A0E,4A00,...,4A08. stall[grant] drops one cycle after the first write and tag_wen fires on the write at offset 8.
